// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter sharing one memory port: latches a single request,
// drives READ/WRITE for ACCESS_CYCLES cycles, then spends one turnaround cycle acknowledging it.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 26,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic                  ACK0,
  output logic                  ACK1,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  BUSY,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  inout  wire  [DATA_WIDTH-1:0] MEM_DATA
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    owner_reg, owner_next;
  logic                    we_reg, we_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic                    last_reg, last_next;
  logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
  logic                    grant_port;

  logic [1:0]              req_vec;
  logic [1:0]              we_vec;
  logic [1:0]              ack_vec;
  logic [ADDR_WIDTH-1:0]   addr_arr  [2];
  logic [DATA_WIDTH-1:0]   wdata_arr [2];

  // Gather the two requester ports into indexable form so the owner can select them.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign req_vec[gi]   = (gi == 0) ? REQ0   : REQ1;
      assign we_vec[gi]    = (gi == 0) ? WE0    : WE1;
      assign addr_arr[gi]  = (gi == 0) ? ADDR0  : ADDR1;
      assign wdata_arr[gi] = (gi == 0) ? WDATA0 : WDATA1;
      assign ack_vec[gi]   = (state_reg == RESP) && (owner_reg == 1'(gi));
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      owner_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      last_reg  <= 1'b1;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      last_reg  <= last_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    owner_next = owner_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    last_next  = last_reg;
    rdata_next = rdata_reg;
    // On a tie the port that was not served last wins.
    grant_port = (req_vec == 2'b11) ? ~last_reg : req_vec[1];
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          owner_next = grant_port;
          we_next    = we_vec[grant_port];
          addr_next  = addr_arr[grant_port];
          wdata_next = wdata_arr[grant_port];
          cnt_next   = CNT_LOAD;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          if (!we_reg) rdata_next = MEM_DATA;
          state_next = RESP;
        end
      end
      RESP: begin
        last_next  = owner_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs decode straight from state so a reset releases them at once.
  assign MEM_ADDR  = (state_reg == ACCESS) ? addr_reg : '0;
  assign MEM_READ  = (state_reg == ACCESS) && !we_reg;
  assign MEM_WRITE = (state_reg == ACCESS) && we_reg;
  assign MEM_DATA  = ((state_reg == ACCESS) && we_reg) ? wdata_reg : 'z;
  assign BUSY      = (state_reg != IDLE);
  assign RDATA     = rdata_reg;
  assign ACK0      = ack_vec[0];
  assign ACK1      = ack_vec[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: DUT a (ACCESS_CYCLES=2) with a scoreboard monitor,
// DUT b (ACCESS_CYCLES=1) for the single-cycle early-drop case.
module tb_mem_bus_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 26;
  localparam int AC_A = 2;
  localparam int AC_B = 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic          a_req0, a_req1, a_we0, a_we1;
  logic [AW-1:0] a_addr0, a_addr1;
  logic [DW-1:0] a_wdata0, a_wdata1;
  logic          a_ack0, a_ack1, a_busy, a_mem_read, a_mem_write;
  logic [DW-1:0] a_rdata;
  logic [AW-1:0] a_mem_addr;
  tri1  [DW-1:0] a_mem_data;

  logic          b_req0, b_req1, b_we0, b_we1;
  logic [AW-1:0] b_addr0, b_addr1;
  logic [DW-1:0] b_wdata0, b_wdata1;
  logic          b_ack0, b_ack1, b_busy, b_mem_read, b_mem_write;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] b_mem_addr;
  tri1  [DW-1:0] b_mem_data;

  typedef struct {
    logic          port;
    logic          we;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACCESS_CYCLES(AC_A)) u_dut_a (
    .CLK(clk), .RST(rst_n),
    .REQ0(a_req0), .REQ1(a_req1), .WE0(a_we0), .WE1(a_we1),
    .ADDR0(a_addr0), .ADDR1(a_addr1), .WDATA0(a_wdata0), .WDATA1(a_wdata1),
    .ACK0(a_ack0), .ACK1(a_ack1), .RDATA(a_rdata), .BUSY(a_busy),
    .MEM_ADDR(a_mem_addr), .MEM_READ(a_mem_read), .MEM_WRITE(a_mem_write),
    .MEM_DATA(a_mem_data)
  );

  mem_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACCESS_CYCLES(AC_B)) u_dut_b (
    .CLK(clk), .RST(rst_n),
    .REQ0(b_req0), .REQ1(b_req1), .WE0(b_we0), .WE1(b_we1),
    .ADDR0(b_addr0), .ADDR1(b_addr1), .WDATA0(b_wdata0), .WDATA1(b_wdata1),
    .ACK0(b_ack0), .ACK1(b_ack1), .RDATA(b_rdata), .BUSY(b_busy),
    .MEM_ADDR(b_mem_addr), .MEM_READ(b_mem_read), .MEM_WRITE(b_mem_write),
    .MEM_DATA(b_mem_data)
  );

  // Memory models: 256 words aliased on addr[7:0], preset to A5A5A5xx on the first edge.
  logic [DW-1:0] a_mem [0:255];
  logic [DW-1:0] b_mem [0:255];
  bit a_init;
  bit b_init;

  always @(posedge clk) begin
    if (!a_init) begin
      for (int i = 0; i < 256; i++) a_mem[i] <= 32'hA5A5_A500 | 32'(i);
      a_init <= 1'b1;
    end else if (a_mem_write) begin
      a_mem[a_mem_addr[7:0]] <= a_mem_data;
    end
  end

  always @(posedge clk) begin
    if (!b_init) begin
      for (int i = 0; i < 256; i++) b_mem[i] <= 32'hA5A5_A500 | 32'(i);
      b_init <= 1'b1;
    end else if (b_mem_write) begin
      b_mem[b_mem_addr[7:0]] <= b_mem_data;
    end
  end

  assign a_mem_data = a_mem_read ? a_mem[a_mem_addr[7:0]] : 'z;
  assign b_mem_data = b_mem_read ? b_mem[b_mem_addr[7:0]] : 'z;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants every cycle, plus scoreboard pop on every acknowledge from DUT a.
  always @(negedge clk) begin
    exp_t e;
    check("rw_excl", 64'(a_mem_read & a_mem_write), 64'(0));
    check("ack_excl", 64'(a_ack0 & a_ack1), 64'(0));
    if (!a_mem_read && !a_mem_write) check("bus_released", 64'(a_mem_data), {32'd0, 32'hFFFF_FFFF});
    if (a_ack0 || a_ack1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 64'({a_ack1, a_ack0}), 64'(0));
      end else begin
        e = sb_q.pop_front();
        $display("txn ack port=%0d we=%0d cyc=%0d rdata=%08h", a_ack1, e.we, cyc, a_rdata);
        check("ack_port", 64'(a_ack1), 64'(e.port));
        check("ack_cycle", 64'(cyc), 64'(e.cyc));
        if (!e.we) check("rdata", 64'(a_rdata), 64'(e.data));
      end
    end
  end

  task automatic drive_port(input logic port, input logic req, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (!port) begin
      a_req0 = req; a_we0 = we; a_addr0 = addr; a_wdata0 = wdata;
    end else begin
      a_req1 = req; a_we1 = we; a_addr1 = addr; a_wdata1 = wdata;
    end
  endtask

  task automatic push_exp(input logic port, input logic we, input logic [DW-1:0] data, input int at);
    exp_t e;
    e.port = port; e.we = we; e.data = data; e.cyc = at;
    sb_q.push_back(e);
  endtask

  // Single transaction on DUT a starting from IDLE; checks the access window too.
  task automatic txn_a(input logic port, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
    int acc;
    bit seen;
    push_exp(port, we, exp_rdata, cyc + 1 + AC_A);
    drive_port(port, 1'b1, we, addr, wdata);
    acc = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (a_mem_read || a_mem_write) begin
        acc++;
        check("acc_addr", 64'(a_mem_addr), 64'(addr));
        check("acc_dir", 64'(a_mem_write), 64'(we));
        if (we) check("acc_wdata", 64'(a_mem_data), 64'(wdata));
      end
      if (port ? a_ack1 : a_ack0) seen = 1'b1;
    end
    check("ack_seen", 64'(seen), 64'(1));
    check("acc_cycles", 64'(acc), 64'(AC_A));
    drive_port(port, 1'b0, we, addr, wdata);
    tick();
  endtask

  task automatic reset_dut(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    int n;
    rst_n = 1'b0;
    a_req0 = 1'b1; a_req1 = 1'b0; a_we0 = 1'b0; a_we1 = 1'b0;
    a_addr0 = '0; a_addr1 = '0; a_wdata0 = '0; a_wdata1 = '0;
    b_req0 = 1'b1; b_req1 = 1'b0; b_we0 = 1'b0; b_we1 = 1'b0;
    b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;

    // Reset held with a pending request.
    repeat (3) begin
      tick();
      check("rst_ack0", 64'(a_ack0), 64'(0));
      check("rst_ack1", 64'(a_ack1), 64'(0));
      check("rst_read", 64'(a_mem_read), 64'(0));
      check("rst_write", 64'(a_mem_write), 64'(0));
      check("rst_bus", 64'(a_mem_data), {32'd0, 32'hFFFF_FFFF});
      check("rst_addr", 64'(a_mem_addr), 64'(0));
      check("rst_rdata", 64'(a_rdata), 64'(0));
      check("rst_busy", 64'(a_busy), 64'(0));
      check("rst_b_ack0", 64'(b_ack0), 64'(0));
      check("rst_b_busy", 64'(b_busy), 64'(0));
    end
    a_req0 = 1'b0;
    b_req0 = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single write then read-back.
    txn_a(1'b0, 1'b1, 26'h000_0010, 32'hDEAD_BEEF, '0);
    txn_a(1'b0, 1'b0, 26'h000_0010, '0, 32'hDEAD_BEEF);

    // Simultaneous requests straight out of reset: port 0 first, port 1 four cycles later.
    reset_dut(2);
    c = cyc;
    push_exp(1'b0, 1'b0, 32'hA5A5_A504, c + 3);
    push_exp(1'b1, 1'b1, '0, c + 7);
    drive_port(1'b0, 1'b1, 1'b0, 26'h000_0004, '0);
    drive_port(1'b1, 1'b1, 1'b1, 26'h000_0008, 32'h1234_5678);
    for (int i = 0; i < 40 && (a_req0 || a_req1); i++) begin
      tick();
      if (a_ack0) a_req0 = 1'b0;
      if (a_ack1) a_req1 = 1'b0;
    end
    check("tie_done", 64'({a_req0, a_req1}), 64'(0));
    tick();

    // Both ports held for six transactions: strict alternation.
    c = cyc;
    for (int i = 0; i < 6; i++)
      push_exp(1'(i % 2), 1'(i % 2), 32'hDEAD_BEEF, c + 3 + 4 * i);
    drive_port(1'b0, 1'b1, 1'b0, 26'h000_0010, '0);
    drive_port(1'b1, 1'b1, 1'b1, 26'h000_0030, 32'h55AA_55AA);
    n = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      tick();
      if (a_ack0 || a_ack1) n++;
    end
    a_req0 = 1'b0;
    a_req1 = 1'b0;
    check("fair_count", 64'(n), 64'(6));
    tick();

    // Port 1's write from the tie test landed in memory.
    txn_a(1'b0, 1'b0, 26'h000_0008, '0, 32'h1234_5678);

    // Reset in the second access cycle of a port 1 write aborts it.
    drive_port(1'b1, 1'b1, 1'b1, 26'h000_0040, 32'h7777_8888);
    tick();
    tick();
    check("abort_pre_write", 64'(a_mem_write), 64'(1));
    rst_n = 1'b0;
    #1;
    check("abort_write", 64'(a_mem_write), 64'(0));
    check("abort_bus", 64'(a_mem_data), {32'd0, 32'hFFFF_FFFF});
    check("abort_busy", 64'(a_busy), 64'(0));
    a_req1 = 1'b0;
    repeat (2) begin
      tick();
      check("abort_ack1", 64'(a_ack1), 64'(0));
    end
    rst_n = 1'b1;
    repeat (3) tick();

    // ACCESS_CYCLES=1: port 1 read at the top address, request dropped after one cycle.
    b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 26'h3FF_FFFF;
    tick();
    check("b_read", 64'(b_mem_read), 64'(1));
    check("b_addr", 64'(b_mem_addr), 64'(26'h3FF_FFFF));
    check("b_ack_early", 64'(b_ack1), 64'(0));
    b_req1 = 1'b0;
    tick();
    check("b_ack1", 64'(b_ack1), 64'(1));
    check("b_rdata", 64'(b_rdata), 64'(32'hA5A5_A5FF));
    check("b_bus_turn", 64'(b_mem_read), 64'(0));
    $display("txn b ack port=1 cyc=%0d rdata=%08h", cyc, b_rdata);
    tick();
    check("b_ack1_gone", 64'(b_ack1), 64'(0));
    check("b_rdata_hold", 64'(b_rdata), 64'(32'hA5A5_A5FF));
    check("b_idle", 64'(b_busy), 64'(0));

    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
